mux_scan_ctrl: RTL

Sequential controller placed directly upstream of the 16:1 gate-level mux tree. It drives the tree's 4-bit select lines, waits for the combinational path to settle, and samples the tree's single-bit output. It supports a single-channel read and a full 16-channel scan, assembling the sampled bits into a 16-bit frame. The frame is delivered downstream over a valid/ready handshake.

---
 rtl/mux_scan_ctrl_pkg.sv | 23 ++
 rtl/mux_scan_ctrl_dwell_timer.sv | 28 ++
 rtl/mux_scan_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_scan_ctrl_pkg.sv
// Shared encodings for the mux-tree scan controller: channel count, select width,
// mode values and FSM states.
package mux_scan_ctrl_pkg;

    localparam int NUM_CH = 16;
    localparam int SEL_W  = 4;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Loadable down-counter shared by the SETTLE and DWELL phases; zero flags expiry.
module mux_dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Drives the 16:1 mux-tree select, waits for settling, samples mux_y and assembles
// a 16-bit frame delivered over a valid/ready handshake.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic [SEL_W-1:0]   ch_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    input  logic               mux_y,
    output logic               busy,
    output logic [NUM_CH-1:0]  frame,
    output logic               frame_valid,
    input  logic               frame_ready
);

    localparam int TMR_W = max_int(4, DWELL_W);
    // Timer holds "cycles remaining minus one", so a phase of N cycles loads N-1.
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE - 1);

    state_t             state;
    logic               mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;
    logic               last_ch;
    logic               chan_end;

    mux_dwell_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign last_ch  = (mode_q == MODE_SINGLE) || (sel == SEL_W'(NUM_CH - 1));
    assign chan_end = ((state == ST_SAMPLE) && (dwell_q == '0)) ||
                      ((state == ST_DWELL) && tmr_zero);

    // Timer reload on every entry into SETTLE or DWELL.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LOAD;
        unique case (state)
            ST_IDLE:   tmr_load = start;
            ST_SAMPLE: begin
                if (dwell_q != '0) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(dwell_q) - TMR_W'(1);
                end else begin
                    tmr_load = !last_ch;
                end
            end
            ST_DWELL:  tmr_load = tmr_zero && !last_ch;
            default:   tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            mode_q      <= MODE_SINGLE;
            dwell_q     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        dwell_q <= dwell;
                        frame   <= '0;
                        sel     <= (mode == MODE_SCAN) ? '0 : ch_sel;
                        busy    <= 1'b1;
                        state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: if (tmr_zero) state <= ST_SAMPLE;
                ST_SAMPLE: begin
                    frame[sel] <= mux_y;
                    if (dwell_q != '0) state <= ST_DWELL;
                end
                ST_DWELL: ;
                ST_DONE: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Shared end-of-channel step from SAMPLE (no dwell) or expired DWELL.
            if (chan_end) begin
                if (last_ch) begin
                    frame_valid <= 1'b1;
                    state       <= ST_DONE;
                end else begin
                    sel   <= sel + SEL_W'(1);
                    state <= ST_SETTLE;
                end
            end
        end
    end

endmodule
